// File: rtl/wb_hazard_ctrl.sv
// Stall/flush controller for a 16-bit MIPS pipeline with a per-register in-flight write scoreboard.
// Latency: all hold/bubble/flush outputs are combinational from ID inputs and registered state; state updates at the next edge.
// Backpressure: a RAW hazard freezes PC and IF/ID and bubbles ID/EX; a taken branch flushes IF/ID and ID/EX and overrides the stall.
//
// Ports: clk/reset (sync, active-high); ID-stage instruction fields (id_*);
//   write-back commit (wb_valid/wb_rd); branch resolution (br_taken);
//   pipeline controls (pc_hold, ifid_hold, idex_bubble, ifid_flush);
//   status (ctrl_state, stall_cnt, sb_err).
module wb_hazard_ctrl #(
   parameter int AW        = 3,
   parameter int CW        = 2,
   parameter int FLUSH_CYC = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs,
   input  logic          id_rs_used,
   input  logic [AW-1:0] id_rt,
   input  logic          id_rt_used,
   input  logic          id_wr_en,
   input  logic [AW-1:0] id_rd,
   input  logic          wb_valid,
   input  logic [AW-1:0] wb_rd,
   input  logic          br_taken,
   output logic          pc_hold,
   output logic          ifid_hold,
   output logic          idex_bubble,
   output logic          ifid_flush,
   output logic [1:0]    ctrl_state,
   output logic [15:0]   stall_cnt,
   output logic          sb_err
);

   localparam int NREG  = 2**AW;
   localparam int FW    = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;
   localparam int FLOAD = (FLUSH_CYC > 1) ? (FLUSH_CYC - 2) : 0;
   localparam logic [CW-1:0] PMAX = '1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } state_t;

   state_t                     state_q, state_d;
   logic [FW-1:0]              fcnt_q, fcnt_d;
   logic [NREG-1:0][CW-1:0]    pend_q, pend_d;
   logic                       err_q, err_d;
   logic [15:0]                stall_cnt_q, stall_cnt_d;

   logic haz_rs, haz_rt, haz, flush_now, issue, inc, dec;

   // Hazard looks only at registered counts: a commit in this cycle does not
   // release a reader until the next cycle.
   assign haz_rs    = id_rs_used && (id_rs != '0) && (pend_q[id_rs] != '0);
   assign haz_rt    = id_rt_used && (id_rt != '0) && (pend_q[id_rt] != '0);
   assign haz       = id_valid && (haz_rs || haz_rt);
   assign flush_now = br_taken || (state_q == ST_FLUSH);

   assign ifid_flush  = flush_now;
   assign idex_bubble = flush_now || haz;
   assign pc_hold     = haz && !flush_now;
   assign ifid_hold   = haz && !flush_now;

   assign issue = id_valid && !haz && !flush_now;
   assign inc   = issue && id_wr_en && (id_rd != '0);
   assign dec   = wb_valid && (wb_rd != '0);

   assign ctrl_state = state_q;
   assign stall_cnt  = stall_cnt_q;
   assign sb_err     = err_q;

   // Control FSM: branch wins from any state; FLUSH counts down, RUN/STALL
   // simply track the current hazard.
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      if (br_taken) begin
         if (FLUSH_CYC > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FW'(FLOAD);
         end else begin
            state_d = ST_RUN;
            fcnt_d  = '0;
         end
      end else if (state_q == ST_FLUSH) begin
         if (fcnt_q != '0) begin
            fcnt_d = fcnt_q - 1'b1;
         end else begin
            state_d = ST_RUN;
         end
      end else begin
         state_d = haz ? ST_STALL : ST_RUN;
      end
   end

   // Scoreboard: r0 is never touched. A simultaneous inc and dec on one
   // register cancel out and cannot raise an error.
   always_comb begin
      pend_d = pend_q;
      err_d  = err_q;
      for (int i = 1; i < NREG; i++) begin
         if (inc && (id_rd == AW'(i)) && !(dec && (wb_rd == AW'(i)))) begin
            if (pend_q[i] == PMAX) begin
               err_d = 1'b1;
            end else begin
               pend_d[i] = pend_q[i] + 1'b1;
            end
         end else if (dec && (wb_rd == AW'(i)) && !(inc && (id_rd == AW'(i)))) begin
            if (pend_q[i] == '0) begin
               err_d = 1'b1;
            end else begin
               pend_d[i] = pend_q[i] - 1'b1;
            end
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (pc_hold && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         fcnt_q      <= '0;
         pend_q      <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         fcnt_q      <= fcnt_d;
         pend_q      <= pend_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
